// File: rtl/reward_engine.sv
// reward_engine: fetches a neighbour-table entry (and, if needed, the best
// hop's cost), then produces a signed saturating reward with cluster-penalty
// and loop detection. Result is held on done_reward until done_prev drops.
module reward_engine #(
    parameter int WORD_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int NUM_FIELDS      = 5,
    parameter int ENTRY_STRIDE    = 8,
    parameter int TABLE_BASE      = 0,
    parameter int NUM_ENTRIES     = 16,
    parameter int MEM_LATENCY     = 1,
    parameter int CLUSTER_PENALTY = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WORD_WIDTH-1:0]            _action,
    input  logic [WORD_WIDTH-1:0]            _besthop,
    output logic [ADDR_WIDTH-1:0]            address,
    input  logic [WORD_WIDTH-1:0]            mem_data_out,
    output logic [NUM_FIELDS*WORD_WIDTH-1:0] reward_data_out,
    output logic [WORD_WIDTH-1:0]            reward_value,
    output logic [2:0]                       reward_flags,
    input  logic [WORD_WIDTH-1:0]            MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0]            MY_CLUSTER_ID,
    input  logic                             done_prev,
    output logic                             done_reward
);

    localparam int SW = WORD_WIDTH + 2;
    localparam int CW = $clog2(NUM_FIELDS + 1);
    localparam logic signed [SW-1:0] SMAX = $signed({3'b000, {(WORD_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] SMIN = $signed({3'b111, {(WORD_WIDTH-1){1'b0}}});
    localparam logic signed [SW-1:0] PEN  = SW'(CLUSTER_PENALTY);
    localparam logic [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [WORD_WIDTH-1:0] N_ENT    = WORD_WIDTH'(NUM_ENTRIES);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CALC, DONE} state_t;

    state_t                                  state_q, state_d;
    logic [WORD_WIDTH-1:0]                   act_q, act_d, best_q, best_d;
    logic [WORD_WIDTH-1:0]                   node_q, node_d, clu_q, clu_d;
    logic                                    rng_q, rng_d;
    logic [CW-1:0]                           iss_q, iss_d, cap_q, cap_d;
    // one bit per outstanding read; bit MEM_LATENCY marks data ready to capture
    logic [MEM_LATENCY:0]                    pipe_q, pipe_d;
    logic [NUM_FIELDS-1:0][WORD_WIDTH-1:0]   fld_q, fld_d;
    logic [WORD_WIDTH-1:0]                   costb_q, costb_d;
    logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
    logic [NUM_FIELDS-1:0][WORD_WIDTH-1:0]   rdo_q, rdo_d;
    logic [WORD_WIDTH-1:0]                   rv_q, rv_d;
    logic [2:0]                              flags_q, flags_d;
    logic                                    done_q, done_d;

    logic [WORD_WIDTH-1:0]                   cost_a, cost_b, sat;
    logic signed [SW-1:0]                    diff;
    logic                                    foreign, loop;

    function automatic logic [ADDR_WIDTH-1:0] base(input logic [WORD_WIDTH-1:0] i);
        return ADDR_WIDTH'(TABLE_BASE) + ADDR_WIDTH'(i) * ADDR_WIDTH'(ENTRY_STRIDE);
    endfunction

    // reward arithmetic from the captured entry, widened so nothing wraps before saturation
    always_comb begin
        cost_a  = fld_q[2];
        cost_b  = (act_q == best_q) ? cost_a : costb_q;
        foreign = (fld_q[1] != clu_q);
        loop    = (fld_q[0] == node_q);
        diff    = $signed({2'b00, cost_b}) - $signed({2'b00, cost_a});
        if (foreign) diff = diff - PEN;
        if (diff > SMAX)      sat = SMAX[WORD_WIDTH-1:0];
        else if (diff < SMIN) sat = MOST_NEG;
        else                  sat = diff[WORD_WIDTH-1:0];
    end

    // next-state and datapath control for the fetch/compute/handshake sequence
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        best_d  = best_q;
        node_d  = node_q;
        clu_d   = clu_q;
        rng_d   = rng_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        pipe_d  = {pipe_q[MEM_LATENCY-1:0], 1'b0};
        fld_d   = fld_q;
        costb_d = costb_q;
        addr_d  = addr_q;
        rdo_d   = rdo_q;
        rv_d    = rv_q;
        flags_d = flags_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (done_prev) begin
                    act_d  = _action;
                    best_d = _besthop;
                    node_d = MY_NODE_ID;
                    clu_d  = MY_CLUSTER_ID;
                    if (_action >= N_ENT || _besthop >= N_ENT) begin
                        // bad index: skip memory entirely, address stays put
                        rng_d   = 1'b1;
                        state_d = CALC;
                    end else begin
                        rng_d     = 1'b0;
                        addr_d    = base(_action);
                        pipe_d[0] = 1'b1;
                        iss_d     = CW'(1);
                        cap_d     = '0;
                        state_d   = RD_A;
                    end
                end
            end
            RD_A: begin
                if (iss_q < CW'(NUM_FIELDS)) begin
                    addr_d    = base(act_q) + ADDR_WIDTH'(iss_q);
                    pipe_d[0] = 1'b1;
                    iss_d     = iss_q + CW'(1);
                end
                if (pipe_q[MEM_LATENCY]) begin
                    fld_d[cap_q] = mem_data_out;
                    cap_d        = cap_q + CW'(1);
                    if (cap_q == CW'(NUM_FIELDS - 1)) begin
                        if (act_q != best_q) begin
                            addr_d    = base(best_q) + ADDR_WIDTH'(2);
                            pipe_d[0] = 1'b1;
                            state_d   = RD_B;
                        end else begin
                            state_d   = CALC;
                        end
                    end
                end
            end
            RD_B: begin
                if (pipe_q[MEM_LATENCY]) begin
                    costb_d = mem_data_out;
                    state_d = CALC;
                end
            end
            CALC: begin
                rdo_d   = rng_q ? '0 : fld_q;
                rv_d    = (rng_q || loop) ? MOST_NEG : sat;
                flags_d = rng_q ? 3'b100 : {1'b0, loop, foreign};
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!done_prev) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers, all cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            act_q   <= '0;
            best_q  <= '0;
            node_q  <= '0;
            clu_q   <= '0;
            rng_q   <= 1'b0;
            iss_q   <= '0;
            cap_q   <= '0;
            pipe_q  <= '0;
            fld_q   <= '0;
            costb_q <= '0;
            addr_q  <= '0;
            rdo_q   <= '0;
            rv_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            best_q  <= best_d;
            node_q  <= node_d;
            clu_q   <= clu_d;
            rng_q   <= rng_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            pipe_q  <= pipe_d;
            fld_q   <= fld_d;
            costb_q <= costb_d;
            addr_q  <= addr_d;
            rdo_q   <= rdo_d;
            rv_q    <= rv_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign address         = addr_q;
    assign reward_data_out = rdo_q;
    assign reward_value    = rv_q;
    assign reward_flags    = flags_q;
    assign done_reward     = done_q;

endmodule

// File: tb/tb_reward_engine.sv
// Scoreboard bench for reward_engine: stimulus pushes expected results,
// a monitor pops and compares on each rising done_reward.
module tb_reward_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] act = '0, best = '0;
    logic [15:0] address;
    logic [15:0] mem_data_out;
    logic [79:0] reward_data_out;
    logic [15:0] reward_value;
    logic [2:0]  reward_flags;
    logic [15:0] my_node = 16'd2, my_clu = 16'd3;
    logic        done_prev = 1'b0;
    logic        done_reward;

    int total = 0, bad = 0, cyc = 0;

    typedef struct {
        logic [79:0]       data;
        logic [15:0]       val;
        logic [2:0]        fl;
        int                lat;
        int                e0;
        int                naddr;
        logic [5:0][15:0]  addrs;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] addr_log[$];
    logic [15:0] mem [0:255];
    logic [15:0] rd_q;

    reward_engine dut (
        .clock(clk), .reset(reset), ._action(act), ._besthop(best),
        .address(address), .mem_data_out(mem_data_out),
        .reward_data_out(reward_data_out), .reward_value(reward_value),
        .reward_flags(reward_flags), .MY_NODE_ID(my_node),
        .MY_CLUSTER_ID(my_clu), .done_prev(done_prev), .done_reward(done_reward)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // single-cycle-latency synchronous memory
    always @(posedge clk) rd_q <= mem[address[7:0]];
    assign mem_data_out = rd_q;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic logic [79:0] pack(input logic [15:0] f0, f1, f2, f3, f4);
        return {f4, f3, f2, f1, f0};
    endfunction

    // address logger: records every change of the read address
    initial begin
        logic [15:0] last;
        last = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last = '0;
                addr_log.delete();
            end else if (address != last) begin
                addr_log.push_back(address);
                last = address;
            end
        end
    end

    // monitor: compare each new result against the head of the scoreboard
    initial begin
        logic             prev;
        exp_t             e;
        logic [5:0][15:0] g;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_reward && !prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got 1 want 0");
                end else begin
                    e = sb.pop_front();
                    chk("latency", 96'(cyc - e.e0), 96'(e.lat));
                    chk("data", 96'(reward_data_out), 96'(e.data));
                    chk("value", 96'(reward_value), 96'(e.val));
                    chk("flags", 96'(reward_flags), 96'(e.fl));
                    chk("addr_cnt", 96'(addr_log.size()), 96'(e.naddr));
                    g = '0;
                    for (int i = 0; i < addr_log.size() && i < 6; i++) g[i] = addr_log[i];
                    chk("addr_seq", 96'(g), 96'(e.addrs));
                    addr_log.delete();
                end
            end
            prev = done_reward;
        end
    end

    task automatic run_op(input int a, input int b, input logic [79:0] d, input logic [15:0] v,
                          input logic [2:0] f, input int lat, input int abase, input int extra,
                          input bit hold);
        exp_t e;
        bit   seen;
        @(negedge clk);
        act = 16'(a);
        best = 16'(b);
        done_prev = 1'b1;
        e.data = d; e.val = v; e.fl = f; e.lat = lat; e.e0 = cyc + 1;
        e.addrs = '0;
        e.naddr = 0;
        if (abase >= 0) begin
            for (int k = 0; k < 5; k++) e.addrs[k] = 16'(abase + k);
            e.naddr = 5;
            if (extra >= 0) begin
                e.addrs[5] = 16'(extra);
                e.naddr = 6;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!hold) done_prev = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done_reward) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 96'(seen), 96'(1));
        if (!seen) begin
            void'(sb.pop_back());
            done_prev = 1'b0;
            @(negedge clk);
        end else if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk("hold_high", 96'(done_reward), 96'(1));
            end
            done_prev = 1'b0;
            @(negedge clk);
            chk("hold_drop", 96'(done_reward), 96'(0));
        end else begin
            @(negedge clk);
            chk("pulse_one", 96'(done_reward), 96'(0));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[16] = 12; mem[17] = 3; mem[18] = 0;      mem[19] = 1;      mem[20] = 2;
        mem[26] = 0;
        mem[34] = 16'hFFFF;
        mem[40] = 9;  mem[41] = 3; mem[42] = 10;     mem[43] = 0;      mem[44] = 0;
        mem[48] = 7;  mem[49] = 3; mem[50] = 14;     mem[51] = 16'h55; mem[52] = 16'h66;
        mem[56] = 11; mem[57] = 8; mem[58] = 16'hFFFF; mem[59] = 16'h1234; mem[60] = 16'hABCD;
        mem[64] = 2;  mem[65] = 3; mem[66] = 5;
        mem[72] = 13; mem[73] = 4; mem[74] = 10;
        mem[82] = 20;

        repeat (2) @(negedge clk);
        chk("rst_addr", 96'(address), 96'(0));
        chk("rst_done", 96'(done_reward), 96'(0));
        chk("rst_outs", 96'({reward_data_out, reward_value, reward_flags}), 96'(0));
        reset = 1'b0;

        // same hop, different hop (held handshake), negative diff
        run_op(5, 5, pack(9, 3, 10, 0, 0), 16'h0000, 3'b000, 7, 40, -1, 1'b0);
        run_op(5, 6, pack(9, 3, 10, 0, 0), 16'h0004, 3'b000, 9, 40, 50, 1'b1);
        run_op(6, 5, pack(7, 3, 14, 16'h55, 16'h66), 16'hFFFC, 3'b000, 9, 48, 42, 1'b0);
        // foreign with negative saturation, foreign without saturation, positive saturation
        run_op(7, 3, pack(11, 8, 16'hFFFF, 16'h1234, 16'hABCD), 16'h8000, 3'b001, 9, 56, 26, 1'b0);
        run_op(9, 10, pack(13, 4, 10, 0, 0), 16'h0006, 3'b001, 9, 72, 82, 1'b0);
        run_op(2, 4, pack(12, 3, 0, 1, 2), 16'h7FFF, 3'b000, 9, 16, 34, 1'b0);
        // loop
        run_op(8, 8, pack(2, 3, 5, 0, 0), 16'h8000, 3'b010, 7, 64, -1, 1'b0);
        // range errors on action and on besthop
        run_op(16, 5, 80'h0, 16'h8000, 3'b100, 1, -1, -1, 1'b0);
        run_op(1, 20, 80'h0, 16'h8000, 3'b100, 1, -1, -1, 1'b1);

        // reset during RD_A, outputs hold 0x8000 from the previous op
        @(negedge clk);
        act = 16'd5;
        best = 16'd6;
        done_prev = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_prev = 1'b0;
        @(negedge clk);
        chk("pre_rst_addr", 96'(address), 96'(41));
        reset = 1'b1;
        #1;
        chk("midrst_addr", 96'(address), 96'(0));
        chk("midrst_done", 96'(done_reward), 96'(0));
        chk("midrst_outs", 96'({reward_data_out, reward_value, reward_flags}), 96'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // back-to-back after reset
        run_op(5, 5, pack(9, 3, 10, 0, 0), 16'h0000, 3'b000, 7, 40, -1, 1'b0);
        run_op(5, 6, pack(9, 3, 10, 0, 0), 16'h0004, 3'b000, 9, 40, 50, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 96'(sb.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reward_engine.md
# reward_engine

Parametrised successor to the routing reward block. On a `done_prev` handshake it fetches the neighbour-table entry for the chosen `_action` from the shared word memory. When `_action` differs from `_besthop`, it also fetches the best hop's cost. It then computes a signed, saturating reward with cluster-penalty and loop detection, and returns the packed entry plus the reward on `done_reward`. It sits between the memory and the Q-update stage of the learning pipeline.

## Interface
- `WORD_WIDTH`, 16, memory word and field width
- `ADDR_WIDTH`, 16, memory address width
- `NUM_FIELDS`, 5, words per entry returned, ≥3 (field0 = neighbour node id, field1 = neighbour cluster id, field2 = hop cost)
- `ENTRY_STRIDE`, 8, word distance between entries, ≥`NUM_FIELDS`
- `TABLE_BASE`, 0, word address of entry 0
- `NUM_ENTRIES`, 16, valid entry indices 0..`NUM_ENTRIES`-1
- `MEM_LATENCY`, 1, cycles from registered address to valid read data (1 or 2)
- `CLUSTER_PENALTY`, 4, subtracted when neighbour is in a foreign cluster

Ports:
- `clock` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-high reset
- `_action` in `WORD_WIDTH` chosen neighbour index
- `_besthop` in `WORD_WIDTH` current best neighbour index
- `address` out `ADDR_WIDTH` memory read address, registered
- `mem_data_out` in `WORD_WIDTH` memory read data
- `reward_data_out` out `NUM_FIELDS*WORD_WIDTH` action entry, field0 in LSBs
- `reward_value` out `WORD_WIDTH` signed reward
- `reward_flags` out 3 {range_err, loop, foreign}
- `MY_NODE_ID` in `WORD_WIDTH` own node id
- `MY_CLUSTER_ID` in `WORD_WIDTH` own cluster id
- `done_prev` in 1 start request, level
- `done_reward` out 1 result valid, level

## Operation
- **Reset values.** All outputs are 0, the FSM is in IDLE, and the capture registers are cleared.
- **FSM states.** IDLE → RD_A → (RD_B) → CALC → DONE → IDLE.
- **IDLE.** When `done_prev`=1, latch `_action`, `_besthop`, `MY_NODE_ID` and `MY_CLUSTER_ID`.
  - If `_action` ≥ `NUM_ENTRIES` or `_besthop` ≥ `NUM_ENTRIES`, go to CALC with range_err=1 and issue no memory reads.
- **Entry base.** base(i) = `TABLE_BASE` + i*`ENTRY_STRIDE`, truncated to `ADDR_WIDTH` (wrap-around is allowed).
- **RD_A.** Issue base(a)+0..`NUM_FIELDS`-1 on consecutive cycles, pipelined.
  - Each word is captured `MEM_LATENCY` cycles after its address.
  - Word k goes into slot k of `reward_data_out`.
- **RD_B.** Entered only if action ≠ besthop. Issue the single address base(b)+2 and capture cost_b.
  - If action = besthop, RD_B is skipped and cost_b = cost_a.
- **CALC.** Compute in `WORD_WIDTH`+2-bit signed arithmetic, then saturate to the `WORD_WIDTH` signed range.
  - diff = cost_b − cost_a, with costs treated as unsigned.
  - foreign = (field1 ≠ MY_CLUSTER_ID); if foreign, diff −= `CLUSTER_PENALTY`.
  - loop = (field0 = MY_NODE_ID).
  - If loop or range_err, reward = most-negative value.
  - On range_err, `reward_data_out` = 0.
- **DONE.** Outputs are registered and held.
  - `done_reward`=1 while `done_prev`=1.
  - `done_prev`=0 → `done_reward`=0 on the next edge and the FSM returns to IDLE.
  - Outputs keep their values until the next CALC.
- **`address` outside reads.** `address` holds its last value outside the read phases.

## Timing
- E0 is the edge on which IDLE samples `done_prev`=1. N=`NUM_FIELDS`, L=`MEM_LATENCY`.
- The first address is valid after E0.
- The last A word is captured at E0+N+L.
- action = besthop: `done_reward` rises after E0+N+L+1 (7 cycles at defaults).
- action ≠ besthop: RD_B address is registered at E0+N+L and captured at E0+N+2L+1; `done_reward` rises after E0+N+2L+2 (9 cycles at defaults).
- range_err: `done_reward` rises after E0+1.
- `done_prev` dropping before DONE does not abort the operation. `done_reward` pulses for exactly one cycle, then the FSM returns to IDLE.
- A new operation needs `done_prev` low for at least one edge after DONE.
- Asynchronous `reset` mid-operation clears everything immediately. No partial result is ever flagged valid.

## Test plan
- **Same-hop case.**
  - Stimulus: action=besthop=5, `MY_CLUSTER_ID`=3, `MY_NODE_ID`=2; entry 5 = {9, 3, 10, 0, 0}.
  - Response: reads at addresses 40..44; reward_value=0; flags=000; done after 7 cycles.
- **Different-hop case.**
  - Stimulus: action=5 (cost 10, cluster 3), besthop=6 (cost 14).
  - Response: reward=+4; one extra read at address 50; done after 9 cycles.
- **Foreign cluster with saturation.**
  - Stimulus: cost_a=0xFFFF, cost_b=0, cluster ≠ 3.
  - Response: reward=0x8000; foreign=1.
- **Loop.**
  - Stimulus: field0=2 = `MY_NODE_ID`.
  - Response: reward=0x8000; loop=1.
- **Range error.**
  - Stimulus: action=16.
  - Response: no address change; range_err=1; done after E0+1; `reward_data_out`=0.
- **Reset mid-RD_A and handshake.**
  - Stimulus: assert reset during RD_A; separately, hold `done_prev` high past DONE.
  - Response: reset clears all outputs at once; `done_reward` stays high until `done_prev` falls, then drops on the next edge; back-to-back operations still meet the timing above.
